prio_tree: RTL and testbench
============================

Name: prio_tree

Overview:
- Parameterised max-finder comparator tree.
- Takes N unsigned W-bit values and reports the index of the largest value, plus the value itself.
- Used as the priority-selection stage: the entry with the highest priority value wins, and ties go to the lower index.
- Output is registered; an optional per-level pipeline trades latency for timing.

Parameters:
- N, 8, number of input values; must be a power of two, N >= 2.
- W, 32, width of each value in bits; values are unsigned.
- IDXW, $clog2(N), width of the index output (3 for N=8).
- PIPELINE, 0, selects the register placement.
  - 0: combinational tree, output register only.
  - 1: register after every tree level.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- in_valid  input  1  the values array is valid this cycle.
- values  input  N x W  unpacked array values[0..N-1]; index 0 is the first element.
- out  output  IDXW  index of the maximum value.
- out_max  output  W  the maximum value, equal to values[out] for the sampled input.
- out_valid  output  1  out and out_max correspond to an accepted in_valid.

Behaviour:
- Tree structure:
  - LEVELS = log2(N) levels of 2:1 compare-select nodes.
  - Level 0 pairs elements (2k, 2k+1).
  - Each node carries the pair {value, index}.
- Node rule:
  - Compare a (lower index) against b (higher index), unsigned.
  - Select b only if b.value > a.value; otherwise select a.
  - Equal values therefore keep the lower index, so the global tie-break is: lowest index among the maxima wins.
- Index width: a node's index is extended by one bit per level, so the final index is IDXW bits and exact.
- PIPELINE=0:
  - Root result is registered on the rising edge of clk.
  - Latency is 1 cycle: inputs sampled at edge k appear on out/out_max after edge k.
  - out_valid <= in_valid on each edge.
- PIPELINE=1:
  - Every level's {value, index} pairs, plus a valid bit, are registered.
  - Latency is LEVELS cycles (3 for N=8).
  - Throughput is one result per cycle.
- in_valid=0:
  - PIPELINE=0: the data registers hold their previous contents.
  - PIPELINE=1: valid=0 propagates through the stages and the stage data may update freely.
  - In both modes out_valid is 0 for that slot.
  - Consumers ignore out/out_max when out_valid=0.
- Reset:
  - Asynchronous: when reset=1, out=0, out_max=0, out_valid=0 immediately, and all pipeline stage registers and valid bits are 0.
  - Reset asserted mid-operation discards in-flight results.
  - After reset deasserts, the first out_valid occurs exactly the latency after the first accepted in_valid.
- Boundaries:
  - All values equal (including all zero) -> out=0.
  - Maximum value 2^W-1 is handled unsigned, so it beats 2^(W-1)-1.
  - A single maximum at index N-1 -> out=N-1.
- No X propagation: with all inputs known, the outputs are always known after reset.

Test Plan:
- Set PIPELINE=0, values={8,9,6,1,5,5,7,6} (values[0]=8), in_valid=1 -> out=1, out_max=9, out_valid=1 one cycle later.
- Set values={5,5,5,5,5,5,5,5} -> out=0, out_max=5. Then values={3,7,2,7,0,7,1,1} -> out=1, out_max=7 (lowest tied index).
- Set values={0,0,0,0,0,0,0,32'hFFFFFFFF} -> out=7. Then values[3]=32'h7FFFFFFF, values[6]=32'h80000000, others 0 -> out=6 (unsigned compare).
- Set PIPELINE=1 and stream {8,9,6,1,5,5,7,6}, {1,2,3,4,5,6,7,8}, {9,0,0,0,0,0,0,0} on consecutive cycles -> out = 1, 7, 0 on three consecutive cycles, with the first one 3 cycles after the first input; out_valid high for exactly those 3 cycles.
- Drop in_valid for one cycle mid-stream -> a gap of exactly one cycle in out_valid at the matching output slot.
- Assert reset for a partial cycle while results are in flight -> out=0, out_max=0, out_valid=0 asynchronously; no stale valid appears after release.

Source files
------------

// File: rtl/prio_tree.sv
// prio_tree: max-finder comparator tree over N unsigned W-bit values.
// Reports the index of the largest value (lowest index wins ties) and the
// value itself. PIPELINE=0 registers only the root result. PIPELINE=1
// registers every tree level, giving LEVELS cycles of latency at full
// throughput.
module prio_tree #(
  parameter int N        = 8,
  parameter int W        = 32,
  parameter int IDXW     = $clog2(N),
  parameter int PIPELINE = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [W-1:0]    values [0:N-1],
  output logic [IDXW-1:0] out,
  output logic [W-1:0]    out_max,
  output logic            out_valid
);

  localparam int LEVELS = $clog2(N);

  // The higher-index side wins only when strictly greater, so ties keep the
  // lower index at every node and therefore globally.
  function automatic logic b_wins(input logic [W-1:0] a, input logic [W-1:0] b);
    b_wins = (b > a);
  endfunction

  if (PIPELINE == 0) begin : g_comb
    logic [W-1:0]    tv_s [0:N-1];
    logic [IDXW-1:0] ti_s [0:N-1];
    logic [W-1:0]    max_r;
    logic [IDXW-1:0] idx_r;
    logic            vld_r;

    // Reduce the inputs in place, one level per pass: slot k takes the
    // winner of slots (2k, 2k+1) of the previous level.
    always_comb begin
      for (int k = 0; k < N; k++) begin
        tv_s[k] = values[k];
        ti_s[k] = IDXW'(k);
      end
      for (int l = 0; l < LEVELS; l++) begin
        for (int k = 0; k < (N >> (l + 1)); k++) begin
          if (b_wins(tv_s[2*k], tv_s[2*k+1])) begin
            tv_s[k] = tv_s[2*k+1];
            ti_s[k] = ti_s[2*k+1];
          end else begin
            tv_s[k] = tv_s[2*k];
            ti_s[k] = ti_s[2*k];
          end
        end
      end
    end

    // Output register: capture the root on accepted inputs, hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        max_r <= '0;
        idx_r <= '0;
        vld_r <= 1'b0;
      end else begin
        vld_r <= in_valid;
        if (in_valid) begin
          max_r <= tv_s[0];
          idx_r <= ti_s[0];
        end
      end
    end

    assign out       = idx_r;
    assign out_max   = max_r;
    assign out_valid = vld_r;
  end else begin : g_pipe
    logic [W-1:0]      nv_s   [0:LEVELS-1][0:N/2-1];
    logic [IDXW-1:0]   ni_s   [0:LEVELS-1][0:N/2-1];
    logic [W-1:0]      st_v_r [0:LEVELS-1][0:N/2-1];
    logic [IDXW-1:0]   st_i_r [0:LEVELS-1][0:N/2-1];
    logic [LEVELS-1:0] vld_r;

    // Next-state of every stage: level 0 compares input pairs, deeper levels
    // compare pairs held in the previous stage register. Unused slots are 0.
    always_comb begin
      for (int l = 0; l < LEVELS; l++) begin
        for (int k = 0; k < N/2; k++) begin
          nv_s[l][k] = '0;
          ni_s[l][k] = '0;
        end
      end
      for (int k = 0; k < N/2; k++) begin
        if (b_wins(values[2*k], values[2*k+1])) begin
          nv_s[0][k] = values[2*k+1];
          ni_s[0][k] = IDXW'(2*k+1);
        end else begin
          nv_s[0][k] = values[2*k];
          ni_s[0][k] = IDXW'(2*k);
        end
      end
      for (int l = 1; l < LEVELS; l++) begin
        for (int k = 0; k < (N >> (l + 1)); k++) begin
          if (b_wins(st_v_r[l-1][2*k], st_v_r[l-1][2*k+1])) begin
            nv_s[l][k] = st_v_r[l-1][2*k+1];
            ni_s[l][k] = st_i_r[l-1][2*k+1];
          end else begin
            nv_s[l][k] = st_v_r[l-1][2*k];
            ni_s[l][k] = st_i_r[l-1][2*k];
          end
        end
      end
    end

    // Stage registers advance every cycle; the valid bit travels alongside
    // the data so invalid slots simply flow through.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_r <= '0;
        for (int l = 0; l < LEVELS; l++) begin
          for (int k = 0; k < N/2; k++) begin
            st_v_r[l][k] <= '0;
            st_i_r[l][k] <= '0;
          end
        end
      end else begin
        vld_r[0] <= in_valid;
        for (int l = 1; l < LEVELS; l++) begin
          vld_r[l] <= vld_r[l-1];
        end
        for (int l = 0; l < LEVELS; l++) begin
          for (int k = 0; k < N/2; k++) begin
            st_v_r[l][k] <= nv_s[l][k];
            st_i_r[l][k] <= ni_s[l][k];
          end
        end
      end
    end

    assign out       = st_i_r[LEVELS-1][0];
    assign out_max   = st_v_r[LEVELS-1][0];
    assign out_valid = vld_r[LEVELS-1];
  end

endmodule

// File: tb/tb_prio_tree.sv
// tb_prio_tree: drives one stimulus stream into a PIPELINE=0 and a
// PIPELINE=1 instance and checks both against a linear-scan reference with
// a latency history, plus directed literal expectations.
module tb_prio_tree;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] vals [0:7];

  logic [2:0]  d0_out, d1_out;
  logic [31:0] d0_max, d1_max;
  logic        d0_valid, d1_valid;

  int passed = 0;
  int total  = 0;

  prio_tree #(.N(8), .W(32), .PIPELINE(0)) u_p0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .values(vals),
    .out(d0_out), .out_max(d0_max), .out_valid(d0_valid)
  );

  prio_tree #(.N(8), .W(32), .PIPELINE(1)) u_p1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .values(vals),
    .out(d1_out), .out_max(d1_max), .out_valid(d1_valid)
  );

  always #5 clk = ~clk;

  // Reference: scan left to right, replace only on strictly greater.
  function automatic int ref_idx(input logic [31:0] v [0:7]);
    int b = 0;
    for (int i = 1; i < 8; i++) begin
      if (v[i] > v[b]) b = i;
    end
    return b;
  endfunction

  int ref_i;
  always_comb ref_i = ref_idx(vals);

  // Model state: h_*[0] is the slot sampled at the latest edge, h_*[2] three
  // edges ago; m0_* is the last accepted result (held across invalid slots).
  logic        h_vld [0:2] = '{1'b0, 1'b0, 1'b0};
  logic [2:0]  h_idx [0:2] = '{3'd0, 3'd0, 3'd0};
  logic [31:0] h_max [0:2] = '{32'd0, 32'd0, 32'd0};
  logic [2:0]  m0_idx = 3'd0;
  logic [31:0] m0_max = 32'd0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        h_vld[i] <= 1'b0;
        h_idx[i] <= 3'd0;
        h_max[i] <= 32'd0;
      end
      m0_idx <= 3'd0;
      m0_max <= 32'd0;
    end else begin
      h_vld[0] <= in_valid;
      h_idx[0] <= 3'(ref_i);
      h_max[0] <= vals[ref_i];
      for (int i = 1; i < 3; i++) begin
        h_vld[i] <= h_vld[i-1];
        h_idx[i] <= h_idx[i-1];
        h_max[i] <= h_max[i-1];
      end
      if (in_valid) begin
        m0_idx <= 3'(ref_i);
        m0_max <= vals[ref_i];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    check("p0_valid", {63'd0, d0_valid}, {63'd0, h_vld[0]});
    check("p0_idx",   {61'd0, d0_out},   {61'd0, m0_idx});
    check("p0_max",   {32'd0, d0_max},   {32'd0, m0_max});
    check("p1_valid", {63'd0, d1_valid}, {63'd0, h_vld[2]});
    if (h_vld[2] || reset) begin
      check("p1_idx", {61'd0, d1_out}, {61'd0, h_idx[2]});
      check("p1_max", {32'd0, d1_max}, {32'd0, h_max[2]});
    end
  end

  task automatic set_vals(input logic [31:0] v0, input logic [31:0] v1,
                          input logic [31:0] v2, input logic [31:0] v3,
                          input logic [31:0] v4, input logic [31:0] v5,
                          input logic [31:0] v6, input logic [31:0] v7,
                          input logic vld);
    vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
    vals[4] = v4; vals[5] = v5; vals[6] = v6; vals[7] = v7;
    in_valid = vld;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic vec_a(input logic vld);
    set_vals(32'd8, 32'd9, 32'd6, 32'd1, 32'd5, 32'd5, 32'd7, 32'd6, vld);
  endtask
  task automatic vec_f(input logic vld);
    set_vals(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, vld);
  endtask
  task automatic vec_g(input logic vld);
    set_vals(32'd9, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, vld);
  endtask
  task automatic vec_b(input logic vld);
    set_vals(32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5, vld);
  endtask

  task automatic p0_expect(input string name, input logic [2:0] idx, input logic [31:0] mx);
    check({name, "_idx"}, {61'd0, d0_out}, {61'd0, idx});
    check({name, "_max"}, {32'd0, d0_max}, {32'd0, mx});
    check({name, "_vld"}, {63'd0, d0_valid}, 64'd1);
  endtask

  task automatic p1_expect(input string name, input logic [2:0] idx, input logic [31:0] mx);
    check({name, "_idx"}, {61'd0, d1_out}, {61'd0, idx});
    check({name, "_max"}, {32'd0, d1_max}, {32'd0, mx});
    check({name, "_vld"}, {63'd0, d1_valid}, 64'd1);
  endtask

  initial begin
    set_vals(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_p0_idx", {61'd0, d0_out}, 64'd0);
    check("rst_p0_vld", {63'd0, d0_valid}, 64'd0);
    check("rst_p1_vld", {63'd0, d1_valid}, 64'd0);
    check("rst_p1_max", {32'd0, d1_max}, 64'd0);

    // Single-cycle directed vectors on the unpipelined instance.
    vec_a(1'b1); step(); p0_expect("p0_a", 3'd1, 32'd9);
    vec_b(1'b1); step(); p0_expect("p0_equal", 3'd0, 32'd5);
    set_vals(32'd3, 32'd7, 32'd2, 32'd7, 32'd0, 32'd7, 32'd1, 32'd1, 1'b1);
    step(); p0_expect("p0_tie", 3'd1, 32'd7);
    set_vals(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b1);
    step(); p0_expect("p0_last", 3'd7, 32'hFFFF_FFFF);
    set_vals(32'd0, 32'd0, 32'd0, 32'h7FFF_FFFF, 32'd0, 32'd0, 32'h8000_0000, 32'd0, 1'b1);
    step(); p0_expect("p0_unsigned", 3'd6, 32'h8000_0000);
    vec_a(1'b0); step();
    check("p0_hold_idx", {61'd0, d0_out}, 64'd6);
    check("p0_hold_max", {32'd0, d0_max}, 64'h8000_0000);
    check("p0_hold_vld", {63'd0, d0_valid}, 64'd0);
    set_vals(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
    step(); p0_expect("p0_zero", 3'd0, 32'd0);
    in_valid = 1'b0;
    repeat (3) step();

    // Back-to-back stream through the pipelined instance.
    vec_a(1'b1); step();
    vec_f(1'b1); step();
    vec_g(1'b1); step(); p1_expect("p1_s0", 3'd1, 32'd9);
    in_valid = 1'b0;
    step(); p1_expect("p1_s1", 3'd7, 32'd8);
    step(); p1_expect("p1_s2", 3'd0, 32'd9);
    step(); check("p1_s_end", {63'd0, d1_valid}, 64'd0);
    repeat (2) step();

    // One-cycle gap in the middle of a stream.
    vec_a(1'b1); step();
    vec_f(1'b1); step();
    in_valid = 1'b0; step(); p1_expect("p1_g0", 3'd1, 32'd9);
    vec_g(1'b1); step(); p1_expect("p1_g1", 3'd7, 32'd8);
    in_valid = 1'b0; step(); check("p1_gap", {63'd0, d1_valid}, 64'd0);
    step(); p1_expect("p1_g2", 3'd0, 32'd9);
    step(); check("p1_g_end", {63'd0, d1_valid}, 64'd0);
    repeat (2) step();

    // Partial-cycle reset while results are in flight.
    vec_a(1'b1); step();
    vec_f(1'b1); step();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_p1_vld", {63'd0, d1_valid}, 64'd0);
    check("arst_p1_idx", {61'd0, d1_out}, 64'd0);
    check("arst_p1_max", {32'd0, d1_max}, 64'd0);
    check("arst_p0_vld", {63'd0, d0_valid}, 64'd0);
    check("arst_p0_idx", {61'd0, d0_out}, 64'd0);
    check("arst_p0_max", {32'd0, d0_max}, 64'd0);
    #3 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("arst_no_stale", {63'd0, d1_valid}, 64'd0);
    end

    // First accepted input after reset appears exactly LEVELS cycles later.
    vec_b(1'b1); step();
    in_valid = 1'b0; step();
    check("post_rst_early", {63'd0, d1_valid}, 64'd0);
    step(); p1_expect("post_rst", 3'd0, 32'd5);
    step(); check("post_rst_end", {63'd0, d1_valid}, 64'd0);
    repeat (2) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
